// File: rtl/gray_binary_stream_dec.sv
// rtl/gray_binary_stream_dec.sv - two-stage Gray-to-binary stream decoder with single-bit step checking
module gray_binary_stream_dec #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  g,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          step_err,
    input  logic          chk_en,
    output logic [CW-1:0] err_cnt,
    input  logic          err_clr
);

    // Stage 1: captured Gray word and the check enable that travelled with it.
    logic         s1_valid;
    logic [W-1:0] s1_g;
    logic         s1_chk;

    // Reference word for the step check; have_prev is cleared by reset so the
    // first word after reset has nothing to compare against.
    logic [W-1:0] prev_g;
    logic         have_prev;

    // Holds in_ready low until the first clock edge after reset release.
    logic         rdy_q;

    logic         adv1;
    logic         adv2;
    logic         accept;
    logic         load2;
    logic [W-1:0] s1_b;
    logic [W-1:0] diff;
    logic         single_step;
    logic         s1_err;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    // XOR prefix from the MSB down.
    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] gv);
        logic [W-1:0] r;
        r[W-1] = gv[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            r[i] = r[i+1] ^ gv[i];
        end
        return r;
    endfunction

    // Handshake and step-check decode for the word sitting in S1.
    always_comb begin
        adv2        = !out_valid || out_ready;
        adv1        = adv2;
        in_ready    = rdy_q && (!s1_valid || adv1);
        accept      = in_valid && in_ready;
        load2       = adv1 && s1_valid;
        s1_b        = gray2bin(s1_g);
        diff        = s1_g ^ prev_g;
        // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
        single_step = (diff != '0) && ((diff & (diff - W'(1))) == '0);
        s1_err      = s1_chk && have_prev && !single_step;
    end

    // Ready enable comes up one edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // S1 register: load on accept, empty when its word moves on with nothing behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_g     <= '0;
            s1_chk   <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_g     <= g;
            s1_chk   <= chk_en;
        end else if (adv1) begin
            s1_valid <= 1'b0;
        end
    end

    // S2 register: converted word and its step flag; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            b         <= '0;
            step_err  <= 1'b0;
        end else if (adv1) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                b        <= s1_b;
                step_err <= s1_err;
            end
        end
    end

    // Previous-word tracking updates on every S1-to-S2 move, checked or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_g    <= '0;
            have_prev <= 1'b0;
        end else if (load2) begin
            prev_g    <= s1_g;
            have_prev <= 1'b1;
        end
    end

    // Saturating error counter; a clear overrides a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (load2 && s1_err && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_gray_binary_stream_dec.sv
// tb/tb_gray_binary_stream_dec.sv - directed self-checking bench for gray_binary_stream_dec
module tb_gray_binary_stream_dec;

    localparam int W  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  g = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          step_err;
    logic          chk_en = 1'b0;
    logic [CW-1:0] err_cnt;
    logic          err_clr = 1'b0;

    int tests = 0;
    int fails = 0;

    gray_binary_stream_dec #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .g         (g),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .step_err  (step_err),
        .chk_en    (chk_en),
        .err_cnt   (err_cnt),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        #12;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++; if (b !== 4'h0) begin fails++; $display("FAIL reset_b got=%h exp=0", b); end
        tests++; if (step_err !== 1'b0) begin fails++; $display("FAIL reset_step_err got=%b exp=0", step_err); end
        tests++; if (err_cnt !== 2'd0) begin fails++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_release_ready_early got=%b exp=0", in_ready); end
        tick();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_full_sequence;
        logic [W-1:0] gw [17];
        logic [W-1:0] eb [17];
        gw = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
               4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        eb = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
               4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0};
        chk_en    = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k <= 18; k++) begin
            in_valid = (k < 17);
            g        = (k < 17) ? gw[k] : 4'h0;
            if (k < 17) begin
                tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL seq_in_ready k=%0d got=%b exp=1", k, in_ready); end
            end
            tick();
            if (k == 0 || k == 18) begin
                tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL seq_out_valid_idle k=%0d got=%b exp=0", k, out_valid); end
            end else begin
                tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL seq_out_valid k=%0d got=%b exp=1", k, out_valid); end
                tests++; if (b !== eb[k-1]) begin fails++; $display("FAIL seq_b k=%0d got=%0d exp=%0d", k, b, eb[k-1]); end
                tests++; if (step_err !== 1'b0) begin fails++; $display("FAIL seq_step_err k=%0d got=%b exp=0", k, step_err); end
            end
        end
        tests++; if (err_cnt !== 2'd0) begin fails++; $display("FAIL seq_err_cnt got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] bw [3];
        int idx;
        int nout;
        logic acc;
        bw   = '{4'h0, 4'h1, 4'h3};
        idx  = 0;
        nout = 0;
        do_reset();
        chk_en = 1'b1;
        for (int cyc = 0; cyc <= 10; cyc++) begin
            out_ready = (cyc >= 6);
            in_valid  = (idx < 3);
            g         = (idx < 3) ? bw[idx] : 4'h0;
            #1;
            if (cyc >= 2 && cyc <= 5) begin
                tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", cyc, out_valid); end
                tests++; if (b !== 4'h0) begin fails++; $display("FAIL bp_hold_b cyc=%0d got=%0d exp=0", cyc, b); end
                tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
            end
            if (out_valid && out_ready) begin
                tests++; if (b !== nout[W-1:0]) begin fails++; $display("FAIL bp_out_b n=%0d got=%0d exp=%0d", nout, b, nout); end
                nout++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
            #1;
        end
        in_valid = 1'b0;
        tests++; if (nout !== 3) begin fails++; $display("FAIL bp_out_count got=%0d exp=3", nout); end
        tests++; if (idx !== 3) begin fails++; $display("FAIL bp_in_count got=%0d exp=3", idx); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_step_errors;
        logic [W-1:0] sw [4];
        logic [W-1:0] eb [4];
        logic         ee [4];
        sw = '{4'h0, 4'h3, 4'h3, 4'h1};
        eb = '{4'd0, 4'd2, 4'd2, 4'd1};
        ee = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        chk_en    = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            in_valid = (k < 4);
            g        = (k < 4) ? sw[k] : 4'h0;
            tick();
            if (k >= 1) begin
                tests++; if (b !== eb[k-1]) begin fails++; $display("FAIL err_b k=%0d got=%0d exp=%0d", k, b, eb[k-1]); end
                tests++; if (step_err !== ee[k-1]) begin fails++; $display("FAIL err_step k=%0d got=%b exp=%b", k, step_err, ee[k-1]); end
            end
        end
        in_valid = 1'b0;
        tick();
        tests++; if (err_cnt !== 2'd2) begin fails++; $display("FAIL err_cnt got=%0d exp=2", err_cnt); end
    endtask

    task automatic test_chk_disabled;
        logic [W-1:0] cw [2];
        logic [W-1:0] eb [2];
        cw = '{4'h0, 4'hF};
        eb = '{4'd0, 4'd10};
        chk_en    = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k <= 2; k++) begin
            in_valid = (k < 2);
            g        = (k < 2) ? cw[k] : 4'h0;
            tick();
            if (k >= 1) begin
                tests++; if (b !== eb[k-1]) begin fails++; $display("FAIL nochk_b k=%0d got=%0d exp=%0d", k, b, eb[k-1]); end
                tests++; if (step_err !== 1'b0) begin fails++; $display("FAIL nochk_step k=%0d got=%b exp=0", k, step_err); end
            end
        end
        in_valid = 1'b0;
        tick();
        tests++; if (err_cnt !== 2'd2) begin fails++; $display("FAIL nochk_err_cnt got=%0d exp=2", err_cnt); end
    endtask

    task automatic test_saturation;
        logic [W-1:0] sw [6];
        int exp_cnt;
        sw = '{4'h0, 4'h3, 4'h0, 4'h3, 4'h0, 4'h3};
        do_reset();
        chk_en    = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            in_valid = (k < 6);
            g        = (k < 6) ? sw[k] : 4'h0;
            tick();
            if (k >= 1) begin
                exp_cnt = (k - 1 > 3) ? 3 : k - 1;
                tests++; if (step_err !== (k > 1)) begin fails++; $display("FAIL sat_step k=%0d got=%b exp=%b", k, step_err, (k > 1)); end
                tests++; if (err_cnt !== exp_cnt[CW-1:0]) begin fails++; $display("FAIL sat_cnt k=%0d got=%0d exp=%0d", k, err_cnt, exp_cnt); end
            end
        end
        in_valid = 1'b1;
        g        = 4'h0;
        tick();
        in_valid = 1'b0;
        err_clr  = 1'b1;
        tick();
        err_clr = 1'b0;
        tests++; if (step_err !== 1'b1) begin fails++; $display("FAIL clr_step got=%b exp=1", step_err); end
        tests++; if (err_cnt !== 2'd0) begin fails++; $display("FAIL clr_wins got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] rw [3];
        rw = '{4'h5, 4'h5, 4'h6};
        do_reset();
        chk_en    = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            g        = rw[k];
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
        tests++; if (b !== 4'd6) begin fails++; $display("FAIL mid_pre_b got=%0d exp=6", b); end
        tests++; if (step_err !== 1'b1) begin fails++; $display("FAIL mid_pre_step got=%b exp=1", step_err); end
        tests++; if (err_cnt !== 2'd1) begin fails++; $display("FAIL mid_pre_cnt got=%0d exp=1", err_cnt); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mid_pre_ready got=%b exp=0", in_ready); end
        #1;
        rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
        tests++; if (b !== 4'h0) begin fails++; $display("FAIL mid_rst_b got=%0d exp=0", b); end
        tests++; if (step_err !== 1'b0) begin fails++; $display("FAIL mid_rst_step got=%b exp=0", step_err); end
        tests++; if (err_cnt !== 2'd0) begin fails++; $display("FAIL mid_rst_cnt got=%0d exp=0", err_cnt); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_ready got=%b exp=0", in_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mid_rel_ready_early got=%b exp=0", in_ready); end
        tick();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_rel_ready got=%b exp=1", in_ready); end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        g         = 4'h6;
        tick();
        in_valid = 1'b0;
        tick();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_first_valid got=%b exp=1", out_valid); end
        tests++; if (b !== 4'd4) begin fails++; $display("FAIL mid_first_b got=%0d exp=4", b); end
        tests++; if (step_err !== 1'b0) begin fails++; $display("FAIL mid_first_step got=%b exp=0", step_err); end
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_backpressure();
        test_step_errors();
        test_chk_disabled();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
